// File: rtl/csr_if.sv
// CSR access bundle between the EX-stage ALU (master) and the CSR register file (slave).
interface csr_if;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_illegal;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        instret_inc;
  logic        wr_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, instret_inc,
    input  rd_data, rd_illegal, wr_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, instret_inc,
    output rd_data, rd_illegal, wr_err
  );
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: mscratch, 64-bit mcycle/minstret, constant misa/mhartid.
// Reads are combinational with no write bypass; writes commit on the rising edge.
module csr_regfile #(
  parameter logic [31:0] MISA_VAL = 32'h40000100,
  parameter logic [31:0] HARTID   = 32'h0,
  parameter bit          COUNT_EN = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  csr_if.slave   bus
);

  logic [31:0] mscratch;
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic        wr_err_q;

  logic        wr_mscratch, wr_mcycle_lo, wr_mcycle_hi, wr_minstret_lo, wr_minstret_hi;
  logic        wr_legal;

  always_comb begin
    bus.rd_data    = '0;
    bus.rd_illegal = 1'b0;
    case (bus.rd_addr)
      12'h340:          bus.rd_data = mscratch;
      12'hB00, 12'hC00: bus.rd_data = mcycle[31:0];
      12'hB80, 12'hC80: bus.rd_data = mcycle[63:32];
      12'hB02, 12'hC02: bus.rd_data = minstret[31:0];
      12'hB82, 12'hC82: bus.rd_data = minstret[63:32];
      12'h301:          bus.rd_data = MISA_VAL;
      12'hF14:          bus.rd_data = HARTID;
      default:          bus.rd_illegal = 1'b1;
    endcase
  end

  // Only these five addresses accept writes; every other address is read-only or unimplemented.
  always_comb begin
    wr_mscratch    = 1'b0;
    wr_mcycle_lo   = 1'b0;
    wr_mcycle_hi   = 1'b0;
    wr_minstret_lo = 1'b0;
    wr_minstret_hi = 1'b0;
    case (bus.wr_addr)
      12'h340: wr_mscratch    = bus.wr_en;
      12'hB00: wr_mcycle_lo   = bus.wr_en;
      12'hB80: wr_mcycle_hi   = bus.wr_en;
      12'hB02: wr_minstret_lo = bus.wr_en;
      12'hB82: wr_minstret_hi = bus.wr_en;
      default: ;
    endcase
    wr_legal = wr_mscratch | wr_mcycle_lo | wr_mcycle_hi | wr_minstret_lo | wr_minstret_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mscratch <= '0;
      mcycle   <= '0;
      minstret <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= bus.wr_en & ~wr_legal;

      if (wr_mscratch)
        mscratch <= bus.wr_data;

      // A write to either half replaces that half and suppresses this cycle's increment.
      if (wr_mcycle_lo)
        mcycle <= {mcycle[63:32], bus.wr_data};
      else if (wr_mcycle_hi)
        mcycle <= {bus.wr_data, mcycle[31:0]};
      else if (COUNT_EN)
        mcycle <= mcycle + 64'd1;

      if (wr_minstret_lo)
        minstret <= {minstret[63:32], bus.wr_data};
      else if (wr_minstret_hi)
        minstret <= {bus.wr_data, minstret[31:0]};
      else if (COUNT_EN && bus.instret_inc)
        minstret <= minstret + 64'd1;
    end
  end

  assign bus.wr_err = wr_err_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Randomized and directed bench for csr_regfile against an architectural CSR model.
module tb_csr_regfile;

  localparam logic [31:0] MISA_VAL = 32'h40000100;
  localparam logic [31:0] HARTID   = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_if bus();

  csr_regfile #(.MISA_VAL(MISA_VAL), .HARTID(HARTID), .COUNT_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Architectural state of the model.
  logic [31:0] m_scratch;
  logic [63:0] m_cycle;
  logic [63:0] m_instret;
  logic        m_err;
  bit          model_on = 1'b0;

  function automatic bit writable(input logic [11:0] a);
    return (a == 12'h340) || (a == 12'hB00) || (a == 12'hB80) ||
           (a == 12'hB02) || (a == 12'hB82);
  endfunction

  function automatic logic [32:0] model_read(input logic [11:0] a);
    // {illegal, data}
    case (a)
      12'h340:          return {1'b0, m_scratch};
      12'hB00, 12'hC00: return {1'b0, m_cycle[31:0]};
      12'hB80, 12'hC80: return {1'b0, m_cycle[63:32]};
      12'hB02, 12'hC02: return {1'b0, m_instret[31:0]};
      12'hB82, 12'hC82: return {1'b0, m_instret[63:32]};
      12'h301:          return {1'b0, MISA_VAL};
      12'hF14:          return {1'b0, HARTID};
      default:          return {1'b1, 32'h0};
    endcase
  endfunction

  // Model step on every rising edge; inputs are stable here since they change 1 unit later.
  always @(posedge clk) begin
    if (rst) begin
      m_scratch = 32'h0;
      m_cycle   = 64'h0;
      m_instret = 64'h0;
      m_err     = 1'b0;
      model_on  = 1'b1;
    end else if (model_on) begin
      logic [63:0] nc, ni;
      nc = m_cycle + 64'd1;
      ni = m_instret + (bus.instret_inc ? 64'd1 : 64'd0);
      m_err = bus.wr_en && !writable(bus.wr_addr);
      if (bus.wr_en) begin
        if (bus.wr_addr == 12'h340) m_scratch = bus.wr_data;
        if (bus.wr_addr == 12'hB00) nc = {m_cycle[63:32], bus.wr_data};
        if (bus.wr_addr == 12'hB80) nc = {bus.wr_data, m_cycle[31:0]};
        if (bus.wr_addr == 12'hB02) ni = {m_instret[63:32], bus.wr_data};
        if (bus.wr_addr == 12'hB82) ni = {bus.wr_data, m_instret[31:0]};
      end
      m_cycle   = nc;
      m_instret = ni;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (model_on) begin
      logic [32:0] e;
      e = model_read(bus.rd_addr);
      checks++;
      if (bus.rd_data !== e[31:0]) begin
        errors++;
        $display("FAIL model_rd_data addr=%h got=%h exp=%h t=%0t", bus.rd_addr, bus.rd_data, e[31:0], $time);
      end
      checks++;
      if (bus.rd_illegal !== e[32]) begin
        errors++;
        $display("FAIL model_rd_illegal addr=%h got=%b exp=%b t=%0t", bus.rd_addr, bus.rd_illegal, e[32], $time);
      end
      checks++;
      if (bus.wr_err !== m_err) begin
        errors++;
        $display("FAIL model_wr_err got=%b exp=%b t=%0t", bus.wr_err, m_err, $time);
      end
    end
  end

  task automatic cyc(input logic r, input logic [11:0] ra, input logic we,
                     input logic [11:0] wa, input logic [31:0] wd, input logic inc);
    rst             = r;
    bus.rd_addr     = ra;
    bus.wr_en       = we;
    bus.wr_addr     = wa;
    bus.wr_data     = wd;
    bus.instret_inc = inc;
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  logic [11:0] addr_tab [14] = '{12'h340, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                 12'hC02, 12'hC82, 12'h301, 12'hF14, 12'h123, 12'hB01, 12'h7FF};

  function automatic logic [11:0] pick_addr();
    if ($urandom_range(0, 9) < 8) return addr_tab[$urandom_range(0, 13)];
    return 12'($urandom);
  endfunction

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFFFFFF - 32'($urandom_range(0, 3));
      1:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    cyc(1, 12'hB00, 0, 12'h0, 32'h0, 0); nxt();

    cyc(0, 12'hB00, 0, 12'h0, 32'h0, 0); chk("mcycle_after_rst", bus.rd_data, 32'd0);
                                          chk("wr_err_after_rst", 32'(bus.wr_err), 32'd0); nxt();
    cyc(0, 12'hC00, 0, 12'h0, 32'h0, 0); chk("cycle_1", bus.rd_data, 32'd1); nxt();
    cyc(0, 12'hB00, 0, 12'h0, 32'h0, 0); chk("mcycle_2", bus.rd_data, 32'd2); nxt();
    cyc(0, 12'hC00, 0, 12'h0, 32'h0, 0); chk("cycle_3", bus.rd_data, 32'd3); nxt();

    cyc(0, 12'h340, 1, 12'h340, 32'hDEADBEEF, 0); chk("mscratch_same_cycle", bus.rd_data, 32'h0); nxt();
    cyc(0, 12'h340, 0, 12'h0, 32'h0, 0); chk("mscratch_next", bus.rd_data, 32'hDEADBEEF); nxt();

    cyc(0, 12'hB00, 1, 12'hB00, 32'hFFFFFFFE, 0); nxt();
    cyc(0, 12'hB00, 1, 12'hB80, 32'h0, 0); chk("mcycle_written_lo", bus.rd_data, 32'hFFFFFFFE); nxt();
    cyc(0, 12'hB00, 0, 12'h0, 32'h0, 0); chk("mcycle_hold_on_hi_wr", bus.rd_data, 32'hFFFFFFFE); nxt();
    cyc(0, 12'hB00, 0, 12'h0, 32'h0, 0); chk("mcycle_ffffffff", bus.rd_data, 32'hFFFFFFFF); nxt();
    cyc(0, 12'hB00, 0, 12'h0, 32'h0, 0); chk("mcycle_wrap_lo", bus.rd_data, 32'h0); nxt();
    cyc(0, 12'hB80, 0, 12'h0, 32'h0, 0); chk("mcycleh_carry", bus.rd_data, 32'h1); nxt();

    cyc(0, 12'hC00, 1, 12'hC00, 32'h1234, 0); chk("wr_err_quiet", 32'(bus.wr_err), 32'd0); nxt();
    cyc(0, 12'hC00, 0, 12'h0, 32'h0, 0); chk("wr_err_ro_pulse", 32'(bus.wr_err), 32'd1);
                                          chk("cycle_unaffected", bus.rd_data, 32'd3); nxt();
    cyc(0, 12'hC00, 0, 12'h0, 32'h0, 0); chk("wr_err_ro_clear", 32'(bus.wr_err), 32'd0); nxt();

    cyc(0, 12'hF14, 1, 12'h123, 32'h5, 0); nxt();
    cyc(0, 12'h123, 0, 12'h0, 32'h0, 0); chk("wr_err_unimpl", 32'(bus.wr_err), 32'd1);
                                          chk("unimpl_rd_zero", bus.rd_data, 32'h0);
                                          chk("unimpl_illegal", 32'(bus.rd_illegal), 32'd1); nxt();
    cyc(0, 12'hF14, 0, 12'h0, 32'h0, 0); chk("mhartid", bus.rd_data, HARTID);
                                          chk("mhartid_legal", 32'(bus.rd_illegal), 32'd0); nxt();
    cyc(0, 12'h301, 0, 12'h0, 32'h0, 0); chk("misa", bus.rd_data, MISA_VAL); nxt();

    cyc(0, 12'hB02, 1, 12'hB82, 32'h0, 0); nxt();
    cyc(0, 12'hB02, 1, 12'hB02, 32'h10, 1); nxt();
    cyc(0, 12'hB02, 0, 12'h0, 32'h0, 1); chk("minstret_wr_no_inc", bus.rd_data, 32'h10); nxt();
    cyc(0, 12'hC02, 0, 12'h0, 32'h0, 0); chk("instret_inc", bus.rd_data, 32'h11); nxt();

    cyc(0, 12'h0, 1, 12'h301, 32'h1, 0); nxt();
    cyc(0, 12'h0, 1, 12'hF14, 32'h1, 0); chk("b2b_err_1", 32'(bus.wr_err), 32'd1); nxt();
    cyc(0, 12'h0, 0, 12'h0, 32'h0, 0); chk("b2b_err_2", 32'(bus.wr_err), 32'd1); nxt();
    cyc(0, 12'h0, 0, 12'h0, 32'h0, 0); chk("b2b_err_end", 32'(bus.wr_err), 32'd0); nxt();

    cyc(0, 12'hB00, 1, 12'hB80, 32'h0, 0); nxt();
    cyc(0, 12'hB00, 1, 12'hB02, 32'h7, 0); nxt();
    cyc(0, 12'hB00, 1, 12'hB00, 32'h50, 0); nxt();
    cyc(1, 12'hB02, 1, 12'h340, 32'h99, 1); chk("minstret_before_rst", bus.rd_data, 32'h7); nxt();
    cyc(0, 12'hB00, 0, 12'h0, 32'h0, 0); chk("mcycle_rst_mid", bus.rd_data, 32'h0); nxt();
    cyc(0, 12'hB02, 0, 12'h0, 32'h0, 0); chk("minstret_rst_mid", bus.rd_data, 32'h0); nxt();
    cyc(0, 12'h340, 0, 12'h0, 32'h0, 0); chk("mscratch_rst_mid", bus.rd_data, 32'h0); nxt();
    cyc(0, 12'hB00, 0, 12'h0, 32'h0, 0); chk("mcycle_resume", bus.rd_data, 32'h3); nxt();

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), pick_addr(), 1'($urandom_range(0, 1)),
          pick_addr(), pick_data(), 1'($urandom_range(0, 1)));
      nxt();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
